m_unit: RTL
===========

Name: m_unit

Overview:
- RV32M multiply/divide unit sitting directly downstream of the execute stage.
- Consumes the forwarded operands (op1_selected/op2_selected) and func3 of an M-type instruction (opcode 0110011, func7 0000001) held in EX.
- Stalls the pipeline while it works and returns a registered result tagged with rd for the EX/MEM writeback path.
- Multiply: fixed 2-cycle latency. Divide/remainder: iterative radix-2, 1 bit per cycle.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported; the divider iteration count equals XLEN.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- m_start  input  1  M instruction present in EX (decoded upstream); level, held while the pipeline is stalled.
- pipeline_flush  input  1  kill the in-flight operation.
- op1  input  32  forwarded rs1 value.
- op2  input  32  forwarded rs2 value.
- func3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rd  input  5  destination register of the M instruction.
- m_stall  output  1  freeze IF/ID/EX; combinational.
- m_done  output  1  one-cycle result-valid pulse.
- m_result  output  32  result; valid when m_done=1.
- m_rd  output  5  rd latched at accept.
- m_wb_reg_file  output  1  equals m_done; writeback enable.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - m_done=0, m_result=0, m_rd=0, m_wb_reg_file=0, m_stall=0.
  - All operand, counter and sign registers cleared.
- States: IDLE, MUL, DIV, DONE.
- IDLE: accepts when m_start=1 and pipeline_flush=0. Latches op1, op2, func3, rd. Call the accept cycle T.
  - func3[2]=0: go to MUL.
  - func3[2]=1 with divisor==0 or signed overflow (DIV/REM, op1=0x80000000, op2=0xFFFFFFFF): special-case result latched, go straight to DONE.
  - Otherwise: go to DIV, with counter=XLEN, remainder=0, and the dividend/divisor registers loaded with absolute values for signed ops. Quotient sign = sign(op1) XOR sign(op2); remainder sign = sign(op1).
- m_stall = (IDLE and m_start and !pipeline_flush) or state in {MUL, DIV}. It is 0 in DONE so the instruction advances out of EX.
- MUL (cycle T+1): forms the 64-bit product and registers the selected half into m_result.
  - MUL: low 32 bits.
  - MULH: high 32, signed×signed.
  - MULHSU: high 32, signed op1 × unsigned op2.
  - MULHU: high 32, unsigned×unsigned.
  - Operands are sign- or zero-extended to 33 bits, multiplied, and the upper word taken.
  - Next state DONE. m_done at T+2.
- DIV: restoring algorithm, one quotient bit per cycle, counter decrements. On counter==1 the sign-corrected quotient (DIV/DIVU) or remainder (REM/REMU) is registered into m_result and the next state is DONE. m_done at T+1+XLEN = T+33.
- Special cases (m_done at T+1):
  - DIV/DIVU by 0: 0xFFFFFFFF.
  - REM/REMU by 0: op1.
  - DIV overflow: 0x80000000.
  - REM overflow: 0.
- DONE: m_done=1 and m_wb_reg_file=1 for exactly one cycle; m_result and m_rd stable. m_start is ignored in this cycle, because it is still the same instruction. Next state is always IDLE.
- A back-to-back M instruction is accepted in the IDLE cycle after DONE.
- pipeline_flush=1 in any state: next state IDLE, m_stall=0 in that cycle, and m_done is forced to 0 (including in DONE). No partial result is ever signalled.
- Flush and m_start in the same IDLE cycle: flush wins, nothing is accepted.
- Reset asserted mid-operation: immediate return to the reset values, and the operation is lost.
- m_result holds its last value outside DONE.

Decomposition:
- Shared package m_unit_pkg holds:
  - the func3 localparams (F3_MUL … F3_REMU);
  - the state encoding (2 bits: IDLE, MUL, DIV, DONE);
  - M_OPCODE=7'b0110011 and M_FUNC7=7'b0000001 for upstream decode.
- One sub-module, m_divider: owns the iteration counter, remainder/quotient shift registers, sign fix-up and special-case detection. Interface is start/abs operands/signs in, busy/done/quotient/remainder out.
- The multiplier and the FSM stay in m_unit.

Test Plan:
- MUL 7×(-3) (op2=0xFFFFFFFD), func3=000: m_stall high at T and T+1; m_done at T+2 with m_result=0xFFFFFFEB and m_rd equal to the rd at accept.
- MULH/MULHSU/MULHU with op1=op2=0x80000000:
  - MULH: 0x40000000.
  - MULHSU: 0xC0000000.
  - MULHU: 0x40000000.
  - Each completes in 2 cycles.
- DIV -20/3: m_done at T+33, result 0xFFFFFFFA. REM -20/3: result 0xFFFFFFFE. DIVU 100/7: result 14. REMU 100/7: result 2.
- Special cases:
  - DIVU 5/0: 0xFFFFFFFF.
  - REM 5/0: 5.
  - DIV 0x80000000/0xFFFFFFFF: 0x80000000.
  - REM with the same operands: 0.
  - Each has m_done at T+1 and m_stall only at T.
- Divide with pipeline_flush pulsed at T+10: state returns to IDLE, m_stall drops the same cycle, no m_done. A new MUL issued at T+11 completes normally at T+13.
- rst_n dropped asynchronously mid-divide (T+5): all outputs 0 immediately. After release, m_start held with DIVU 9/2 gives result 4 at 33 cycles after accept, with m_start held through DONE producing no second accept.

Source files
------------

// File: rtl/m_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
// Holds func3 codes, FSM state encoding and the M-extension decode constants.
// Used by upstream decode as well as by m_unit and m_divider.
package m_unit_pkg;

    // func3 encodings of the M-extension instructions
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // Decode constants for upstream: opcode OP with func7 = MULDIV
    localparam logic [6:0] M_OPCODE = 7'b0110011;
    localparam logic [6:0] M_FUNC7  = 7'b0000001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/m_divider.sv
// Iterative radix-2 restoring divider on magnitudes, with sign fix-up and special cases.
// Latency: XLEN cycles after i_start; o_done marks the final iteration (results valid then).
// No backpressure: i_kill aborts; special cases are flagged combinationally from the inputs.
// Ports: i_start/i_kill control; i_dividend/i_divisor are absolute values; i_q_neg/i_r_neg
//        are the result signs; o_special/o_special_result cover divide-by-zero and overflow;
//        o_busy/o_done/o_quotient/o_remainder report the iterative result.
module m_divider
    import m_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic            i_kill,
    input  logic            i_signed,
    input  logic            i_is_rem,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    input  logic            i_q_neg,
    input  logic            i_r_neg,
    output logic            o_special,
    output logic [XLEN-1:0] o_special_result,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_quotient,
    output logic [XLEN-1:0] o_remainder
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] W_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] W_ONE = {{(XLEN-1){1'b0}}, 1'b1};

    logic            r_busy;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_dvsr;
    logic            r_q_neg;
    logic            r_r_neg;

    logic            w_div_zero;
    logic            w_overflow;
    logic [XLEN:0]   w_shift;
    logic [XLEN+1:0] w_diff;
    logic [XLEN-1:0] w_rem_nxt;
    logic [XLEN-1:0] w_quo_nxt;

    // Overflow is MIN / -1: in magnitude form that is |a|=MIN, |b|=1, both negative
    // (divisor sign recovered as q_neg ^ r_neg).
    assign w_div_zero = (i_divisor == '0);
    assign w_overflow = i_signed && i_r_neg && (i_q_neg ^ i_r_neg)
                        && (i_dividend == W_MIN) && (i_divisor == W_ONE);
    assign o_special  = w_div_zero || w_overflow;

    always_comb begin
        o_special_result = '0;
        if (w_div_zero) begin
            // REM by zero returns the original dividend, so undo the magnitude
            o_special_result = i_is_rem ? (i_r_neg ? -i_dividend : i_dividend) : {XLEN{1'b1}};
        end else if (w_overflow) begin
            o_special_result = i_is_rem ? '0 : W_MIN;
        end
    end

    // One restoring step: shift the next dividend bit into the partial remainder and
    // subtract the divisor if it fits. The shifted value is below 2*divisor, so it needs
    // XLEN+1 bits and the difference one more for the borrow.
    assign w_shift   = {r_rem, r_quo[XLEN-1]};
    assign w_diff    = {1'b0, w_shift} - {2'b00, r_dvsr};
    assign w_rem_nxt = w_diff[XLEN+1] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
    assign w_quo_nxt = {r_quo[XLEN-2:0], ~w_diff[XLEN+1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvsr  <= '0;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
        end else if (i_kill) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_busy  <= 1'b1;
            r_cnt   <= CW'(XLEN);
            r_rem   <= '0;
            r_quo   <= i_dividend;
            r_dvsr  <= i_divisor;
            r_q_neg <= i_q_neg;
            r_r_neg <= i_r_neg;
        end else if (r_busy) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_busy && (r_cnt == CW'(1));
    // Final-step values with signs applied; consumed in the cycle o_done is high
    assign o_quotient  = r_q_neg ? -w_quo_nxt : w_quo_nxt;
    assign o_remainder = r_r_neg ? -w_rem_nxt : w_rem_nxt;

endmodule

// File: rtl/m_unit.sv
// RV32M multiply/divide unit behind EX: stalls the pipe and returns a registered result tagged with rd.
// Latency: MUL* done at T+2, DIV/REM at T+1+XLEN, divide special cases at T+1 (T = accept cycle).
// Backpressure: m_stall freezes IF/ID/EX while busy; pipeline_flush kills the op, no partial result.
// Ports: clk/rst_n; m_start/pipeline_flush control; op1/op2/func3/rd operands;
//        m_stall to the pipeline; m_done/m_result/m_rd/m_wb_reg_file to the EX/MEM writeback path.
module m_unit
    import m_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            m_start,
    input  logic            pipeline_flush,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [2:0]      func3,
    input  logic [4:0]      rd,
    output logic            m_stall,
    output logic            m_done,
    output logic [XLEN-1:0] m_result,
    output logic [4:0]      m_rd,
    output logic            m_wb_reg_file
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [XLEN-1:0]   r_op1;
    logic [XLEN-1:0]   r_op2;
    logic [2:0]        r_func3;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_result;

    logic              w_accept;
    logic              w_div_signed;
    logic              w_op1_neg;
    logic              w_op2_neg;
    logic [XLEN-1:0]   w_op1_abs;
    logic [XLEN-1:0]   w_op2_abs;
    logic              w_div_start;
    logic              w_div_special;
    logic [XLEN-1:0]   w_div_special_result;
    logic              w_div_busy;
    logic              w_div_done;
    logic [XLEN-1:0]   w_div_quo;
    logic [XLEN-1:0]   w_div_rem;
    logic [XLEN-1:0]   w_div_result;
    logic [2*XLEN-1:0] w_mul_a;
    logic [2*XLEN-1:0] w_mul_b;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_mul_result;

    assign w_accept = (r_state == S_IDLE) && m_start && !pipeline_flush;

    // Divider operand prep from the live EX operands; DIV/REM (func3[0]=0) are signed
    assign w_div_signed = ~func3[0];
    assign w_op1_neg    = w_div_signed & op1[XLEN-1];
    assign w_op2_neg    = w_div_signed & op2[XLEN-1];
    assign w_op1_abs    = w_op1_neg ? -op1 : op1;
    assign w_op2_abs    = w_op2_neg ? -op2 : op2;
    assign w_div_start  = w_accept && func3[2] && !w_div_special;

    m_divider #(.XLEN(XLEN)) u_divider (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_start          (w_div_start),
        .i_kill           (pipeline_flush),
        .i_signed         (w_div_signed),
        .i_is_rem         (func3[1]),
        .i_dividend       (w_op1_abs),
        .i_divisor        (w_op2_abs),
        .i_q_neg          (w_op1_neg ^ w_op2_neg),
        .i_r_neg          (w_op1_neg),
        .o_special        (w_div_special),
        .o_special_result (w_div_special_result),
        .o_busy           (w_div_busy),
        .o_done           (w_div_done),
        .o_quotient       (w_div_quo),
        .o_remainder      (w_div_rem)
    );

    assign w_div_result = r_func3[1] ? w_div_rem : w_div_quo;

    // Extending to the full product width and keeping the low 2*XLEN bits of the
    // product gives the exact signed/unsigned result for every MULH* variant.
    assign w_mul_a      = {{XLEN{(r_func3 != F3_MULHU) & r_op1[XLEN-1]}}, r_op1};
    assign w_mul_b      = {{XLEN{(r_func3 == F3_MULH) & r_op2[XLEN-1]}}, r_op2};
    assign w_prod       = w_mul_a * w_mul_b;
    assign w_mul_result = (r_func3 == F3_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        m_stall     = 1'b0;
        if (pipeline_flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (m_start) begin
                        m_stall = 1'b1;
                        if (!func3[2]) begin
                            w_state_nxt = S_MUL;
                        end else if (w_div_special) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_state_nxt = S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    m_stall     = 1'b1;
                    w_state_nxt = S_DONE;
                end
                S_DIV: begin
                    m_stall = 1'b1;
                    // Divider busy drops together with done; leave if it was killed underneath
                    if (w_div_done || !w_div_busy) begin
                        w_state_nxt = S_DONE;
                    end
                end
                // m_start is still the same instruction here, so it is ignored
                S_DONE: w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op1    <= '0;
            r_op2    <= '0;
            r_func3  <= '0;
            r_rd     <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op1   <= op1;
            r_op2   <= op2;
            r_func3 <= func3;
            r_rd    <= rd;
            if (func3[2] && w_div_special) begin
                r_result <= w_div_special_result;
            end
        end else if (!pipeline_flush) begin
            if (r_state == S_MUL) begin
                r_result <= w_mul_result;
            end else if (r_state == S_DIV && w_div_done) begin
                r_result <= w_div_result;
            end
        end
    end

    assign m_done        = (r_state == S_DONE) && !pipeline_flush;
    assign m_wb_reg_file = m_done;
    assign m_result      = r_result;
    assign m_rd          = r_rd;

endmodule
